// File: rtl/hsv_pixel_classifier_if.sv
// Pixel stream bundle for the HSV classifier: RGB pixel in, HSV + match out.
// Master drives pixels and observes results; slave is the classifier.
interface hsv_pixel_classifier_if #(
    parameter int IN_W = 4,
    parameter int SB_W = 2
);
    logic            valid_in;
    logic [IN_W-1:0] r_in;
    logic [IN_W-1:0] g_in;
    logic [IN_W-1:0] b_in;
    logic [SB_W-1:0] sb_in;

    logic [8:0]      h_out;
    logic [7:0]      s_out;
    logic [7:0]      v_out;
    logic [SB_W-1:0] sb_out;
    logic            match_out;
    logic            valid_out;

    modport master (
        output valid_in, r_in, g_in, b_in, sb_in,
        input  h_out, s_out, v_out, sb_out, match_out, valid_out
    );

    modport slave (
        input  valid_in, r_in, g_in, b_in, sb_in,
        output h_out, s_out, v_out, sb_out, match_out, valid_out
    );
endinterface

// File: rtl/hsv_pixel_classifier.sv
// Four-stage RGB-to-HSV converter with a hue/saturation/value window match.
// A global enable stalls every stage; reset clears all state and outputs.
module hsv_pixel_classifier #(
    parameter int IN_W = 4,
    parameter int SB_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [8:0] h_lo,
    input  logic [8:0] h_hi,
    input  logic [7:0] s_min,
    input  logic [7:0] v_min,
    hsv_pixel_classifier_if.slave pix
);

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_e;

    // ---------------- S1: scale, max/min, max-channel select
    logic [7:0] r8, g8, b8;

    // MSB-first replication fills 8 bits for any channel width
    for (genvar i = 0; i < 8; i++) begin : g_widen
        assign r8[7-i] = pix.r_in[IN_W-1-(i%IN_W)];
        assign g8[7-i] = pix.g_in[IN_W-1-(i%IN_W)];
        assign b8[7-i] = pix.b_in[IN_W-1-(i%IN_W)];
    end

    logic [7:0] max_c;
    logic [7:0] min_c;
    ch_e        sel_c;

    always_comb begin
        max_c = r8;
        sel_c = CH_R;
        unique case (1'b1)
            (r8 >= g8 && r8 >= b8): begin
                max_c = r8;
                sel_c = CH_R;
            end
            (g8 > r8 && g8 >= b8): begin
                max_c = g8;
                sel_c = CH_G;
            end
            (b8 > r8 && b8 > g8): begin
                max_c = b8;
                sel_c = CH_B;
            end
            default: begin
                max_c = r8;
                sel_c = CH_R;
            end
        endcase
    end

    always_comb begin
        min_c = r8;
        if (g8 < min_c) min_c = g8;
        if (b8 < min_c) min_c = b8;
    end

    logic            s1_v;
    logic [7:0]      s1_r, s1_g, s1_b;
    logic [7:0]      s1_max, s1_min;
    ch_e             s1_sel;
    logic [SB_W-1:0] s1_sb;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v   <= 1'b0;
            s1_r   <= '0;
            s1_g   <= '0;
            s1_b   <= '0;
            s1_max <= '0;
            s1_min <= '0;
            s1_sel <= CH_R;
            s1_sb  <= '0;
        end else if (en) begin
            s1_v   <= pix.valid_in;
            s1_r   <= r8;
            s1_g   <= g8;
            s1_b   <= b8;
            s1_max <= max_c;
            s1_min <= min_c;
            s1_sel <= sel_c;
            s1_sb  <= pix.sb_in;
        end
    end

    // ---------------- S2: delta, signed difference, numerators
    logic [7:0]  delta_c;
    logic [8:0]  d_c;
    logic [7:0]  absd_c;
    logic [13:0] num_h_c;
    logic [15:0] num_s_c;

    always_comb begin
        delta_c = s1_max - s1_min;
        d_c     = '0;
        case (s1_sel)
            CH_R:    d_c = {1'b0, s1_g} - {1'b0, s1_b};
            CH_G:    d_c = {1'b0, s1_b} - {1'b0, s1_r};
            CH_B:    d_c = {1'b0, s1_r} - {1'b0, s1_g};
            default: d_c = '0;
        endcase
        absd_c  = d_c[8] ? 8'(-d_c) : d_c[7:0];
        num_h_c = 14'(absd_c) * 14'd60;
        num_s_c = 16'(delta_c) * 16'd255;
    end

    logic            s2_v;
    ch_e             s2_sel;
    logic            s2_neg;
    logic [7:0]      s2_delta;
    logic [7:0]      s2_max;
    logic [13:0]     s2_num_h;
    logic [15:0]     s2_num_s;
    logic [SB_W-1:0] s2_sb;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v     <= 1'b0;
            s2_sel   <= CH_R;
            s2_neg   <= 1'b0;
            s2_delta <= '0;
            s2_max   <= '0;
            s2_num_h <= '0;
            s2_num_s <= '0;
            s2_sb    <= '0;
        end else if (en) begin
            s2_v     <= s1_v;
            s2_sel   <= s1_sel;
            s2_neg   <= d_c[8];
            s2_delta <= delta_c;
            s2_max   <= s1_max;
            s2_num_h <= num_h_c;
            s2_num_s <= num_s_c;
            s2_sb    <= s1_sb;
        end
    end

    // ---------------- S3: hue offset and saturation divisions
    logic [8:0] q_c;
    logic [7:0] sat_c;

    // |d| <= delta, so the quotient never exceeds 60
    always_comb begin
        q_c   = '0;
        sat_c = '0;
        if (s2_delta != 8'd0)
            q_c = 9'(s2_num_h / 14'(s2_delta));
        if (s2_max != 8'd0)
            sat_c = 8'(s2_num_s / 16'(s2_max));
    end

    logic            s3_v;
    ch_e             s3_sel;
    logic            s3_neg;
    logic            s3_dz;
    logic [8:0]      s3_q;
    logic [7:0]      s3_s;
    logic [7:0]      s3_max;
    logic [SB_W-1:0] s3_sb;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_v   <= 1'b0;
            s3_sel <= CH_R;
            s3_neg <= 1'b0;
            s3_dz  <= 1'b1;
            s3_q   <= '0;
            s3_s   <= '0;
            s3_max <= '0;
            s3_sb  <= '0;
        end else if (en) begin
            s3_v   <= s2_v;
            s3_sel <= s2_sel;
            s3_neg <= s2_neg;
            s3_dz  <= (s2_delta == 8'd0);
            s3_q   <= q_c;
            s3_s   <= sat_c;
            s3_max <= s2_max;
            s3_sb  <= s2_sb;
        end
    end

    // ---------------- S4: hue base/wrap, window compare, outputs
    logic [8:0] h_c;
    logic       in_win_c;
    logic       match_c;

    always_comb begin
        h_c = '0;
        if (!s3_dz) begin
            case (s3_sel)
                CH_R: begin
                    if (!s3_neg)
                        h_c = s3_q;
                    else if (s3_q != 9'd0)
                        h_c = 9'd360 - s3_q;
                    else
                        h_c = 9'd0;
                end
                CH_G:    h_c = s3_neg ? 9'd120 - s3_q : 9'd120 + s3_q;
                CH_B:    h_c = s3_neg ? 9'd240 - s3_q : 9'd240 + s3_q;
                default: h_c = '0;
            endcase
        end
    end

    // h_lo > h_hi means the window wraps through 0 degrees
    always_comb begin
        if (h_lo <= h_hi)
            in_win_c = (h_c >= h_lo) && (h_c <= h_hi);
        else
            in_win_c = (h_c >= h_lo) || (h_c <= h_hi);
        match_c = s3_v && in_win_c
               && (s3_s >= s_min) && (s3_max >= v_min);
    end

    logic [8:0]      out_h;
    logic [7:0]      out_s;
    logic [7:0]      out_v;
    logic [SB_W-1:0] out_sb;
    logic            out_match;
    logic            out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_h     <= '0;
            out_s     <= '0;
            out_v     <= '0;
            out_sb    <= '0;
            out_match <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_h     <= h_c;
            out_s     <= s3_s;
            out_v     <= s3_max;
            out_sb    <= s3_sb;
            out_match <= match_c;
            out_valid <= s3_v;
        end
    end

    assign pix.h_out     = out_h;
    assign pix.s_out     = out_s;
    assign pix.v_out     = out_v;
    assign pix.sb_out    = out_sb;
    assign pix.match_out = out_match;
    assign pix.valid_out = out_valid;

endmodule

// File: tb/tb_hsv_pixel_classifier.sv
// Directed bench for hsv_pixel_classifier (IN_W=4, SB_W=2).
// Scenario tasks run in sequence and compare against hand-derived values.
module tb_hsv_pixel_classifier;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [8:0] h_lo = 9'd0;
    logic [8:0] h_hi = 9'd359;
    logic [7:0] s_min = 8'd0;
    logic [7:0] v_min = 8'd0;

    int n_tests = 0;
    int n_fail  = 0;

    hsv_pixel_classifier_if #(.IN_W(4), .SB_W(2)) pix ();

    hsv_pixel_classifier #(.IN_W(4), .SB_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .h_lo  (h_lo),
        .h_hi  (h_hi),
        .s_min (s_min),
        .v_min (v_min),
        .pix   (pix)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input int g, input int b,
                         input int sb, input logic vld);
        pix.r_in     = r[3:0];
        pix.g_in     = g[3:0];
        pix.b_in     = b[3:0];
        pix.sb_in    = sb[1:0];
        pix.valid_in = vld;
    endtask

    // One isolated pixel; reports any early valid/match and outputs at clock 4
    task automatic run_pixel(input int r, input int g, input int b,
                             input int sb, output logic early,
                             output int h, output int s, output int v,
                             output int sbo, output logic m,
                             output logic vo);
        early = 1'b0;
        drive(r, g, b, sb, 1'b1);
        tick();
        drive(0, 0, 0, 0, 1'b0);
        early = early | pix.valid_out | pix.match_out;
        tick();
        early = early | pix.valid_out | pix.match_out;
        tick();
        early = early | pix.valid_out | pix.match_out;
        tick();
        h   = int'(pix.h_out);
        s   = int'(pix.s_out);
        v   = int'(pix.v_out);
        sbo = int'(pix.sb_out);
        m   = pix.match_out;
        vo  = pix.valid_out;
    endtask

    function automatic void model(input int r, input int g, input int b,
                                  input int lo, input int hi,
                                  input int smin, input int vmin,
                                  output int h, output int s,
                                  output int v, output bit m);
        int r8, g8, b8, mx, mn, dl, d, base, q;
        bit inw;
        r8 = r * 17;
        g8 = g * 17;
        b8 = b * 17;
        if (r8 >= g8 && r8 >= b8) begin
            mx = r8; d = g8 - b8; base = 0;
        end else if (g8 >= b8) begin
            mx = g8; d = b8 - r8; base = 120;
        end else begin
            mx = b8; d = r8 - g8; base = 240;
        end
        mn = r8;
        if (g8 < mn) mn = g8;
        if (b8 < mn) mn = b8;
        dl = mx - mn;
        v  = mx;
        s  = (mx == 0) ? 0 : (255 * dl) / mx;
        if (dl == 0) begin
            h = 0;
        end else begin
            q = (60 * ((d < 0) ? -d : d)) / dl;
            h = (d >= 0) ? base + q : base - q;
            if (h < 0) h = h + 360;
            if (h >= 360) h = h - 360;
        end
        if (lo <= hi) inw = (h >= lo) && (h <= hi);
        else          inw = (h >= lo) || (h <= hi);
        m = inw && (s >= smin) && (v >= vmin);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        tick();
        tick();
        n_tests++;
        if ({pix.h_out, pix.s_out, pix.v_out, pix.sb_out,
             pix.match_out, pix.valid_out} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: h=%0d s=%0d v=%0d sb=%0d m=%b vo=%b, required all 0",
                     pix.h_out, pix.s_out, pix.v_out, pix.sb_out,
                     pix.match_out, pix.valid_out);
        end
        reset = 1'b0;
    endtask

    // columns: r g b sb h s v match
    task automatic test_colours();
        int tv[7][8] = '{
            '{15,  0,  0, 1,   0, 255, 255, 1},
            '{ 0, 15,  0, 2, 120, 255, 255, 1},
            '{ 0,  0, 15, 3, 240, 255, 255, 1},
            '{15,  8,  0, 0,  32, 255, 255, 1},
            '{12,  6,  6, 1,   0, 127, 204, 1},
            '{ 7,  7,  7, 2,   0,   0, 119, 1},
            '{15,  0,  1, 3, 356, 255, 255, 1}
        };
        logic early, m, vo;
        int h, s, v, sbo;
        h_lo = 9'd0; h_hi = 9'd359; s_min = 8'd0; v_min = 8'd0;
        for (int i = 0; i < 7; i++) begin
            run_pixel(tv[i][0], tv[i][1], tv[i][2], tv[i][3],
                      early, h, s, v, sbo, m, vo);
            n_tests++;
            if (early !== 1'b0 || vo !== 1'b1 || h !== tv[i][4] ||
                s !== tv[i][5] || v !== tv[i][6] || sbo !== tv[i][3] ||
                m !== tv[i][7][0]) begin
                n_fail++;
                $display("FAIL colour_%0d: early=%b vo=%b h=%0d s=%0d v=%0d sb=%0d m=%b, required early=0 vo=1 h=%0d s=%0d v=%0d sb=%0d m=%0d",
                         i, early, vo, h, s, v, sbo, m,
                         tv[i][4], tv[i][5], tv[i][6], tv[i][3], tv[i][7]);
            end
        end
    endtask

    task automatic test_wrap_window();
        int tv[6][7] = '{
            '{15,  0,  0,   0, 255, 255, 1},
            '{15,  0,  1, 356, 255, 255, 1},
            '{15,  8,  0,  32, 255, 255, 0},
            '{ 7,  7,  7,   0,   0, 119, 0},
            '{ 3,  0,  0,   0, 255,  51, 1},
            '{ 2,  0,  0,   0, 255,  34, 0}
        };
        logic early, m, vo;
        int h, s, v, sbo;
        h_lo = 9'd350; h_hi = 9'd10; s_min = 8'd100; v_min = 8'd50;
        for (int i = 0; i < 6; i++) begin
            run_pixel(tv[i][0], tv[i][1], tv[i][2], i % 4,
                      early, h, s, v, sbo, m, vo);
            n_tests++;
            if (early !== 1'b0 || vo !== 1'b1 || h !== tv[i][3] ||
                s !== tv[i][4] || v !== tv[i][5] || m !== tv[i][6][0]) begin
                n_fail++;
                $display("FAIL window_%0d: early=%b vo=%b h=%0d s=%0d v=%0d m=%b, required early=0 vo=1 h=%0d s=%0d v=%0d m=%0d",
                         i, early, vo, h, s, v, m,
                         tv[i][3], tv[i][4], tv[i][5], tv[i][6]);
            end
        end
    endtask

    task automatic test_stall();
        h_lo = 9'd0; h_hi = 9'd359; s_min = 8'd0; v_min = 8'd0;
        drive(15, 0, 0, 0, 1'b1);
        tick();
        drive(0, 15, 0, 1, 1'b1);
        tick();
        drive(0, 0, 15, 2, 1'b1);
        tick();
        en = 1'b0;
        drive(5, 9, 3, 1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (pix.valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid_out=%b, required 0",
                         k, pix.valid_out);
            end
        end
        drive(15, 8, 0, 3, 1'b1);
        en = 1'b1;
        tick();
        drive(0, 0, 0, 0, 1'b0);
        n_tests++;
        if (pix.valid_out !== 1'b1 || pix.h_out !== 9'd0 ||
            pix.sb_out !== 2'd0) begin
            n_fail++;
            $display("FAIL stall_a: vo=%b h=%0d sb=%0d, required vo=1 h=0 sb=0",
                     pix.valid_out, pix.h_out, pix.sb_out);
        end
        en = 1'b0;
        tick();
        n_tests++;
        if (pix.valid_out !== 1'b1 || pix.h_out !== 9'd0 ||
            pix.sb_out !== 2'd0 || pix.v_out !== 8'd255) begin
            n_fail++;
            $display("FAIL stall_freeze: vo=%b h=%0d sb=%0d v=%0d, required vo=1 h=0 sb=0 v=255",
                     pix.valid_out, pix.h_out, pix.sb_out, pix.v_out);
        end
        en = 1'b1;
        begin
            int eh[3] = '{120, 240, 32};
            for (int k = 0; k < 3; k++) begin
                tick();
                n_tests++;
                if (pix.valid_out !== 1'b1 || pix.h_out !== eh[k][8:0] ||
                    pix.sb_out !== 2'(k + 1)) begin
                    n_fail++;
                    $display("FAIL stall_order_%0d: vo=%b h=%0d sb=%0d, required vo=1 h=%0d sb=%0d",
                             k, pix.valid_out, pix.h_out, pix.sb_out,
                             eh[k], k + 1);
                end
            end
        end
        tick();
        n_tests++;
        if (pix.valid_out !== 1'b0 || pix.match_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: vo=%b m=%b, required 0 0",
                     pix.valid_out, pix.match_out);
        end
    endtask

    task automatic test_reset_midstream();
        logic early, m, vo, seen;
        int h, s, v, sbo;
        drive(15, 0, 0, 1, 1'b1);
        tick();
        drive(0, 15, 0, 2, 1'b1);
        tick();
        drive(0, 0, 15, 3, 1'b1);
        tick();
        drive(0, 0, 0, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({pix.h_out, pix.s_out, pix.v_out, pix.sb_out,
             pix.match_out, pix.valid_out} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: h=%0d s=%0d v=%0d sb=%0d m=%b vo=%b, required all 0",
                     pix.h_out, pix.s_out, pix.v_out, pix.sb_out,
                     pix.match_out, pix.valid_out);
        end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | pix.valid_out;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ghost: valid_out seen=%b, required 0", seen);
        end
        run_pixel(0, 15, 0, 2, early, h, s, v, sbo, m, vo);
        n_tests++;
        if (early !== 1'b0 || vo !== 1'b1 || h !== 120 || sbo !== 2) begin
            n_fail++;
            $display("FAIL reset_mid_after: early=%b vo=%b h=%0d sb=%0d, required early=0 vo=1 h=120 sb=2",
                     early, vo, h, sbo);
        end
    endtask

    task automatic test_reset_stalled();
        logic seen;
        drive(15, 0, 0, 1, 1'b1);
        tick();
        drive(0, 0, 0, 0, 1'b0);
        en    = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en    = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | pix.valid_out;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stalled: valid_out seen=%b, required 0", seen);
        end
    endtask

    // All 4096 inputs streamed back-to-back through a non-wrapping window
    task automatic test_back_to_back();
        int eh, es, ev, j;
        bit em;
        h_lo = 9'd100; h_hi = 9'd200; s_min = 8'd64; v_min = 8'd80;
        for (int k = 0; k < 4096 + 3; k++) begin
            if (k < 4096)
                drive((k >> 8) & 15, (k >> 4) & 15, k & 15, k & 3, 1'b1);
            else
                drive(0, 0, 0, 0, 1'b0);
            tick();
            if (k >= 3) begin
                j = k - 3;
                model((j >> 8) & 15, (j >> 4) & 15, j & 15,
                      100, 200, 64, 80, eh, es, ev, em);
                n_tests++;
                if (pix.valid_out !== 1'b1 || pix.h_out !== eh[8:0] ||
                    pix.h_out >= 9'd360 || pix.s_out !== es[7:0] ||
                    pix.v_out !== ev[7:0] || pix.sb_out !== 2'(j & 3) ||
                    pix.match_out !== em) begin
                    n_fail++;
                    $display("FAIL sweep_%0d: vo=%b h=%0d s=%0d v=%0d sb=%0d m=%b, required vo=1 h=%0d s=%0d v=%0d sb=%0d m=%b",
                             j, pix.valid_out, pix.h_out, pix.s_out,
                             pix.v_out, pix.sb_out, pix.match_out,
                             eh, es, ev, j & 3, em);
                end
            end
        end
        tick();
        n_tests++;
        if (pix.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_drain: valid_out=%b, required 0", pix.valid_out);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 1'b0);
        test_reset();
        test_colours();
        test_wrap_window();
        test_stall();
        test_reset_midstream();
        test_reset_stalled();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
